// File: rtl/video_framebuffer.sv
// Double-buffered frame store: writes fill the back bank, the VGA stage reads
// the front bank at scaled screen coordinates, and the banks swap on frame_start.
module video_framebuffer #(
    parameter int PIX_W = 12,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int SCALE = 4,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_x,
    input  logic [6:0]       wr_y,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_err,
    input  logic             swap_req,
    output logic             swap_done,
    input  logic             frame_start,
    input  logic             readPixel,
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    output logic [PIX_W-1:0] rgb,
    output logic             rgb_valid
);

    localparam int BANK  = FB_W * FB_H;
    localparam int DEPTH = 2 * BANK;
    localparam int AW    = $clog2(DEPTH);
    localparam int SH    = $clog2(SCALE);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SWAP
    } state_t;

    state_t state;
    state_t state_n;
    logic   front;

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            front <= 1'b0;
        end else begin
            state <= state_n;
            if (state == SWAP) begin
                front <= ~front;
            end
        end
    end

    // wr_ready is held low during rst so a write in that cycle is dropped
    always_comb begin
        state_n   = state;
        wr_ready  = 1'b0;
        swap_done = 1'b0;
        unique case (state)
            IDLE: begin
                wr_ready = ~rst;
                if (swap_req) begin
                    state_n = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    state_n = SWAP;
                end
            end
            SWAP: begin
                swap_done = ~rst;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    logic          wr_fire;
    logic          wr_in;
    logic [AW-1:0] wr_addr;

    assign wr_fire = wr_valid & wr_ready;
    assign wr_in   = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
    assign wr_addr = (front ? AW'(0) : AW'(BANK))
                   + AW'(wr_y) * AW'(FB_W) + AW'(wr_x);

    always_ff @(posedge clk) begin
        if (wr_fire && wr_in) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_fire & ~wr_in;
        end
    end

    logic [CNT_W-1:0] fx;
    logic [CNT_W-1:0] fy;

    generate
        if ((1 << SH) == SCALE) begin : g_shift
            assign fx = hcount >> SH;
            assign fy = vcount >> SH;
        end else begin : g_div
            assign fx = hcount / CNT_W'(SCALE);
            assign fy = vcount / CNT_W'(SCALE);
        end
    endgenerate

    logic          rd_in;
    logic [AW-1:0] rd_addr_c;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          vis;

    assign rd_in     = readPixel && (32'(fx) < FB_W) && (32'(fy) < FB_H);
    assign rd_addr_c = (front ? AW'(BANK) : AW'(0))
                     + AW'(fy) * AW'(FB_W) + AW'(fx);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            rd_en     <= 1'b0;
            vis       <= 1'b0;
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rd_addr   <= rd_addr_c;
            rd_en     <= rd_in;
            vis       <= readPixel;
            rgb       <= rd_en ? mem[rd_addr] : '0;
            rgb_valid <= vis;
        end
    end

endmodule
